// File: rtl/chrono_pkg.sv
// Shared definitions for the stopwatch control front end: FSM encoding and debounce default.
package chrono_pkg;

  typedef enum logic [1:0] {
    ST_STOPPED = 2'd0,
    ST_RUNNING = 2'd1,
    ST_LAP     = 2'd2
  } state_e;

  localparam int unsigned DEFAULT_DEBOUNCE_TICKS = 3;

endpackage

// File: rtl/chrono_debouncer.sv
// One stopwatch button: two-flop synchroniser, tick-based debounce counter and press pulse.
module chrono_debouncer #(
  parameter int unsigned DEBOUNCE_TICKS = chrono_pkg::DEFAULT_DEBOUNCE_TICKS,
  parameter int unsigned CNT_W          = 4
) (
  input  logic qzt_clk,
  input  logic reset,
  input  logic clk_in,
  input  logic btn_raw,
  output logic level,
  output logic press
);

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(DEBOUNCE_TICKS - 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (clk_in) begin
      // The tick that would bring the count to DEBOUNCE_TICKS accepts the new level.
      if (cnt_q == LastCnt) begin
        level_d = sync2_q;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    press_d = level_d & ~level_q;
  end

  always_ff @(posedge qzt_clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/chrono_control_unit.sv
// Stopwatch control: debounced button events, priority resolution and run/pause/lap FSM.
module chrono_control_unit
  import chrono_pkg::*;
#(
  parameter int unsigned DEBOUNCE_TICKS = DEFAULT_DEBOUNCE_TICKS,
  parameter int unsigned CNT_W          = 4
) (
  input  logic       qzt_clk,
  input  logic       reset,
  input  logic       clk_in,
  input  logic       btn_startstop,
  input  logic       btn_lap,
  input  logic       btn_reset,
  output logic       pause,
  output logic       counter_reset,
  output logic       lap_capture,
  output logic       lap_hold,
  output logic [1:0] state
);

  logic [2:0] btn_raw, btn_level, btn_press;

  assign btn_raw = {btn_reset, btn_startstop, btn_lap};

  for (genvar i = 0; i < 3; i++) begin : g_deb
    chrono_debouncer #(
      .DEBOUNCE_TICKS(DEBOUNCE_TICKS),
      .CNT_W         (CNT_W)
    ) u_deb (
      .qzt_clk(qzt_clk),
      .reset  (reset),
      .clk_in (clk_in),
      .btn_raw(btn_raw[i]),
      .level  (btn_level[i]),
      .press  (btn_press[i])
    );
  end

  logic ev_reset, ev_startstop, ev_lap;

  // reset > start/stop > lap; lower-priority events in the same cycle are dropped.
  always_comb begin
    ev_reset     = btn_press[2] & btn_level[2];
    ev_startstop = btn_press[1] & btn_level[1] & ~ev_reset;
    ev_lap       = btn_press[0] & btn_level[0] & ~ev_reset & ~btn_press[1];
  end

  state_e state_q, state_d;
  logic   pause_q, pause_d;
  logic   lap_hold_q, lap_hold_d;
  logic   counter_reset_q, counter_reset_d;
  logic   lap_capture_q, lap_capture_d;

  always_comb begin
    state_d         = state_q;
    counter_reset_d = 1'b0;
    lap_capture_d   = 1'b0;
    case (state_q)
      ST_STOPPED: begin
        if (ev_reset)          counter_reset_d = 1'b1;
        else if (ev_startstop) state_d = ST_RUNNING;
      end
      ST_RUNNING: begin
        if (ev_reset) begin
          counter_reset_d = 1'b1;
        end else if (ev_startstop) begin
          state_d = ST_STOPPED;
        end else if (ev_lap) begin
          state_d       = ST_LAP;
          lap_capture_d = 1'b1;
        end
      end
      ST_LAP: begin
        if (ev_reset) begin
          counter_reset_d = 1'b1;
          state_d         = ST_RUNNING;
        end else if (ev_startstop) begin
          state_d = ST_STOPPED;
        end else if (ev_lap) begin
          state_d = ST_RUNNING;
        end
      end
      default: state_d = ST_STOPPED;
    endcase
    pause_d    = (state_d == ST_STOPPED);
    lap_hold_d = (state_d == ST_LAP);
  end

  always_ff @(posedge qzt_clk) begin
    if (reset) begin
      state_q         <= ST_STOPPED;
      pause_q         <= 1'b1;
      lap_hold_q      <= 1'b0;
      counter_reset_q <= 1'b0;
      lap_capture_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      pause_q         <= pause_d;
      lap_hold_q      <= lap_hold_d;
      counter_reset_q <= counter_reset_d;
      lap_capture_q   <= lap_capture_d;
    end
  end

  assign pause         = pause_q;
  assign lap_hold      = lap_hold_q;
  assign counter_reset = counter_reset_q;
  assign lap_capture   = lap_capture_q;
  assign state         = state_q;

endmodule

// File: doc/chrono_control_unit.md
# chrono_control_unit

Control front end of the start/stop stopwatch. It debounces the three stopwatch pushbuttons (start/stop, lap, reset) and turns each clean press into a one-cycle event. A small state machine then drives the run/pause level, the counter reset pulse, and the lap display freeze that the centi/deci/unit/deca counter chain and the LED output mux consume. It sits between the raw `BTN_*` pins and the counter chain, replacing the undebounced control logic at the stopwatch top.

## Interface
Parameters:
- `DEBOUNCE_TICKS`, default 3: number of consecutive 100 Hz ticks a synchronised button level must hold before it is accepted (30 ms at the default).
- `CNT_W`, default 4: width of each debounce counter. Must satisfy 2^CNT_W > DEBOUNCE_TICKS.

Ports:
- `qzt_clk`, in, 1: 50 MHz master clock; all logic runs on its rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `clk_in`, in, 1: 100 Hz tick from the frequency divider, sampled on `qzt_clk`. The debounce counters treat it as a one-`qzt_clk`-cycle enable.
- `btn_startstop`, in, 1: raw asynchronous button (`BTN_SOUTH`).
- `btn_lap`, in, 1: raw asynchronous button (`BTN_EAST`).
- `btn_reset`, in, 1: raw asynchronous button (`BTN_NORTH`).
- `pause`, out, 1: high means the counters hold. Drives the counters' `set` input.
- `counter_reset`, out, 1: one-cycle pulse that clears the counter chain.
- `lap_capture`, out, 1: one-cycle pulse that tells the lap register to latch the current time.
- `lap_hold`, out, 1: high means the display shows the lap register instead of the live time.
- `state`, out, 2: current FSM state, for LED debug.

## Operation
Input conditioning, per button:
- Two-flop synchroniser.
- Debounce counter: it clears whenever the synchronised level equals the accepted level. On each tick where they differ, it increments. When it reaches `DEBOUNCE_TICKS`, the accepted level takes the synchronised value and the counter clears.
- Press event: a 0→1 transition of the accepted level produces a pulse exactly one `qzt_clk` cycle long.
- Release events and glitches shorter than `DEBOUNCE_TICKS` ticks produce nothing.

Event priority in one cycle: reset > start/stop > lap. Only the highest-priority event present is acted on; the others are discarded, not queued.

FSM states (encoding held in the shared package): STOPPED = 0, RUNNING = 1, LAP = 2. Encoding 3 is illegal and recovers to STOPPED on the next cycle.

Transitions:
- From STOPPED:
  - start/stop → RUNNING.
  - reset → pulse `counter_reset`, stay STOPPED.
  - lap → ignored.
- From RUNNING:
  - start/stop → STOPPED.
  - lap → LAP, pulse `lap_capture`.
  - reset → pulse `counter_reset`, stay RUNNING (counting resumes from 00.00).
- From LAP:
  - lap → RUNNING (display released).
  - start/stop → STOPPED (display released; live stopped time shown).
  - reset → pulse `counter_reset`, go to RUNNING.

Output decode:
- `pause` = (state == STOPPED).
- `lap_hold` = (state == LAP).
- Both outputs are registered.

## Timing
Reset values:
- State: STOPPED.
- Outputs: `pause` = 1, `lap_hold` = 0, `counter_reset` = 0, `lap_capture` = 0, `state` = 0.
- Internal: synchronisers, accepted levels and debounce counters all 0.

Latency and pulse rules:
- Press latency: 2 `qzt_clk` cycles (synchroniser), plus `DEBOUNCE_TICKS` ticks, plus 1 cycle (edge detect). The FSM outputs update one cycle after the event pulse.
- `counter_reset` and `lap_capture` are high for exactly one `qzt_clk` cycle per accepted press.
- A button held indefinitely yields exactly one event.

Boundary conditions:
- `reset` asserted mid-debounce: all counters and accepted levels clear. A button still held when `reset` drops must debounce again and then generates a press.
- `clk_in` stuck high: debounce then counts every `qzt_clk` cycle. This is legal; only the debounce time changes.
- Debounce counter saturation: cannot occur, because the counter clears at `DEBOUNCE_TICKS`.

## Structure
Shared package `chrono_pkg`:
- State encodings `ST_STOPPED`, `ST_RUNNING`, `ST_LAP`.
- Default `DEBOUNCE_TICKS`.

Sub-module `chrono_debouncer`, instanced three times:
- Parameters: `DEBOUNCE_TICKS`, `CNT_W`.
- Ports: `qzt_clk`, `reset`, `clk_in`, `btn_raw`, `level`, `press`.
- Contains the synchroniser, debounce counter and rising-edge pulse.

The top of this block holds only the priority logic and the FSM.

## Test plan
- **Clean start:** after `reset`, hold `btn_startstop` high for 5 ticks → one press. `pause` goes 1→0 and `state` = 1 within 2 + 3 ticks + 2 cycles. `counter_reset` stays 0.
- **Bounce rejection:** toggle `btn_lap` with 1-tick pulses 10 times while RUNNING → no `lap_capture`, state stays RUNNING. Then a 4-tick hold → `lap_capture` high for 1 cycle, `lap_hold` = 1, `state` = 2.
- **Lap release and stop:** in LAP, press `btn_lap` → `state` = 1 and `lap_hold` = 0. Press LAP again, then `btn_startstop` → `state` = 0, `pause` = 1, `lap_hold` = 0.
- **Reset paths:**
  - `btn_reset` in STOPPED → one-cycle `counter_reset`, `pause` stays 1.
  - `btn_reset` in LAP → `counter_reset` pulse, then `state` = 1 and `lap_hold` = 0.
- **Simultaneous presses:** all three buttons debounced on the same tick while RUNNING → only `counter_reset` pulses. State stays RUNNING, no `lap_capture`.
- **Reset mid-debounce and hold:**
  - Assert `reset` 2 ticks into a `btn_startstop` hold (button kept high) → after release of `reset`, exactly one start press occurs 3 ticks later.
  - Holding for 1000 ticks yields no further events.
